reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every subsystem in reset after the system reset, then
// releases the stages one at a time in index order, each waiting for the
// previous stage to report ready. A stage that never becomes ready, or a ready
// that drops after the sequence completes, latches a sticky fault. soft_rst
// restarts the whole sequence from the hold phase.
module reset_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  sys_ready,
  output logic                  fault,
  output logic [2:0]            fault_stage
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_rst_d;
  logic                    sys_ready_d;
  logic                    fault_d;
  logic [2:0]              fault_stage_d;
  logic [7:0]              ready_ext;

  // Widen to 8 bits so the 3-bit stage index always selects in range.
  assign ready_ext = 8'(stage_ready);

  // Deassert one stage's reset, leaving all others untouched.
  function automatic logic [NUM_STAGES-1:0] clear_bit(input logic [NUM_STAGES-1:0] v,
                                                      input logic [2:0] i);
    logic [7:0] e;
    e    = 8'(v);
    e[i] = 1'b0;
    return e[NUM_STAGES-1:0];
  endfunction

  // Lowest-numbered stage whose ready is low.
  function automatic logic [2:0] lowest_low(input logic [NUM_STAGES-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // State, counter, index and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst   <= '1;
      sys_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst   <= stage_rst_d;
      sys_ready   <= sys_ready_d;
      fault       <= fault_d;
      fault_stage <= fault_stage_d;
    end
  end

  // Next-state and next-output logic; soft_rst overrides every transition.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst;
    sys_ready_d   = sys_ready;
    fault_d       = fault;
    fault_stage_d = fault_stage;

    if (soft_rst) begin
      state_d       = S_HOLD;
      cnt_d         = '0;
      idx_d         = '0;
      stage_rst_d   = '1;
      sys_ready_d   = 1'b0;
      fault_d       = 1'b0;
      fault_stage_d = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            stage_rst_d = clear_bit(stage_rst, 3'd0);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (ready_ext[idx_q]) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d     = S_RUN;
              sys_ready_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d       = S_FAULT;
            cnt_d         = '0;
            stage_rst_d   = '1;
            sys_ready_d   = 1'b0;
            fault_d       = 1'b1;
            fault_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            idx_d       = idx_q + 3'd1;
            stage_rst_d = clear_bit(stage_rst, idx_d);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!(&stage_ready)) begin
            state_d       = S_FAULT;
            cnt_d         = '0;
            stage_rst_d   = '1;
            sys_ready_d   = 1'b0;
            fault_d       = 1'b1;
            fault_stage_d = lowest_low(stage_ready);
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. The stimulus thread pushes the output
// transitions it expects (cycle and value) into a queue; a monitor samples the
// outputs on every falling edge and, whenever they change, pops the next
// expectation and compares both the cycle and the new value.
module tb_reset_sequencer;

  localparam int NS = 3;

  logic          clk;
  logic          rst_n;
  logic          soft_rst;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_rst;
  logic          sys_ready;
  logic          fault;
  logic [2:0]    fault_stage;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs;
  logic [7:0] last_obs;

  // Output encodings {stage_rst, sys_ready, fault, fault_stage}.
  localparam logic [7:0] V_RESET = 8'b111_0_0_000;
  localparam logic [7:0] V_REL0  = 8'b110_0_0_000;
  localparam logic [7:0] V_REL1  = 8'b100_0_0_000;
  localparam logic [7:0] V_REL2  = 8'b000_0_0_000;
  localparam logic [7:0] V_RUN   = 8'b000_1_0_000;
  localparam logic [7:0] V_FLT1  = 8'b111_0_1_001;

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .HOLD_CYCLES   (16),
    .GAP_CYCLES    (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_rst   (soft_rst),
    .stage_ready(stage_ready),
    .stage_rst  (stage_rst),
    .sys_ready  (sys_ready),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  assign obs = {stage_rst, sys_ready, fault, fault_stage};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; edge k after a release at count B lands on B+k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int unsigned c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Expected releases with every ready already high, from sequence start b.
  task automatic push_normal(input int unsigned b);
    push(b + 16, V_REL0);
    push(b + 21, V_REL1);
    push(b + 26, V_REL2);
    push(b + 27, V_RUN);
  endtask

  // Monitor: compare each output change against the next expectation.
  initial begin
    exp_t e;
    last_obs = V_RESET;
    forever begin
      @(negedge clk);
      if (obs !== last_obs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(obs), 32'(last_obs));
        end else begin
          e = exp_q.pop_front();
          check("change_cycle", e.cyc == 0 ? 32'(cyc) : 32'(cyc), 32'(e.cyc));
          check("change_value", 32'(obs), 32'(e.val));
        end
        last_obs = obs;
      end
    end
  end

  initial begin
    int unsigned b;
    int unsigned s;

    rst_n       = 1'b0;
    soft_rst    = 1'b0;
    stage_ready = 3'b111;
    repeat (3) tick();
    check("reset_state", 32'(obs), 32'(V_RESET));

    // Plain power-up sequence with every stage ready.
    rst_n = 1'b1;
    b     = cyc;
    push_normal(b);
    wait_until(b + 30);

    // Ready drop in RUN, then soft_rst restarts the whole sequence.
    push(b + 31, V_FLT1);
    stage_ready = 3'b001;
    tick();
    stage_ready = 3'b111;
    wait_until(b + 35);
    s = cyc;
    push(s + 1, V_RESET);
    push_normal(s + 1);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_until(s + 31);

    // Stage 1 reports ready 10 cycles after release; gap then runs 4 edges.
    b = cyc + 1;
    push(b, V_RESET);
    push(b + 16, V_REL0);
    push(b + 21, V_REL1);
    push(b + 36, V_REL2);
    push(b + 37, V_RUN);
    stage_ready = 3'b101;
    soft_rst    = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_until(b + 31);
    stage_ready = 3'b111;
    wait_until(b + 40);

    // soft_rst on the timeout edge wins; the next attempt times out for real.
    b = cyc + 1;
    push(b, V_RESET);
    push(b + 16, V_REL0);
    push(b + 21, V_REL1);
    stage_ready = 3'b001;
    soft_rst    = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_until(b + 84);
    push(b + 85, V_RESET);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    b = b + 85;
    push(b + 16, V_REL0);
    push(b + 21, V_REL1);
    push(b + 85, V_FLT1);
    wait_until(b + 85 + 200);
    check("fault_sticky", 32'(obs), 32'(V_FLT1));

    // Asynchronous reset during the gap after stage 0, then a clean restart.
    b = cyc + 1;
    push(b, V_RESET);
    push(b + 16, V_REL0);
    stage_ready = 3'b111;
    soft_rst    = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_until(b + 18);
    push(b + 18, V_RESET);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs), 32'(V_RESET));
    wait_until(b + 20);
    rst_n = 1'b1;
    s     = cyc;
    push_normal(s);
    wait_until(s + 30);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
